// File: rtl/mem_access_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_pkg : op encoding, FSM states and lane helpers for MEM   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package mem_access_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:         return (off == 2'b00);
            OP_LH, OP_LHU, OP_SH: return !off[0];
            default:              return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:          return 4'b1111;
            OP_LH, OP_LHU, OP_SH:  return off[1] ? 4'b1100 : 4'b0011;
            OP_LB, OP_LBU, OP_SB:  return 4'b0001 << off;
            default:               return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [3:0] op, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [15:0] half;
        logic [7:0]  byt;
        half = off[1] ? rdata[31:16] : rdata[15:0];
        byt  = rdata[{off, 3'b000} +: 8];
        case (op)
            OP_LH:   return {{16{half[15]}}, half};
            OP_LHU:  return {16'h0000, half};
            OP_LB:   return {{24{byt[7]}}, byt};
            OP_LBU:  return {24'h000000, byt};
            default: return rdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit_if : req/ack data-memory bus                        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_align : lane select and sign/zero extension of a read word     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module load_align
    import mem_access_pkg::*;
(
    input  wire logic [3:0]  i_op,
    input  wire logic [1:0]  i_off,
    input  wire logic [31:0] i_rdata,
    output logic      [31:0] o_data
);

    assign o_data = extract_load(i_op, i_off, i_rdata);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit : MEM-stage load/store engine on a req/ack bus      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] Mem_aluout,
    input  wire logic [31:0] Mem_din,
    input  wire logic [3:0]  Mem_op,
    input  wire logic        Mem_flush,
    mem_access_unit_if.master bus,
    output logic             stall,
    output logic      [31:0] load_data,
    output logic             load_valid,
    output logic             exc_adel,
    output logic             exc_ades,
    output logic             exc_bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [29:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d, op_q, op_d;
    logic [31:0]       wdata_q, wdata_d, load_data_q, load_data_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_valid_q, load_valid_d;
    logic              exc_adel_q, exc_adel_d, exc_ades_q, exc_ades_d, exc_bus_q, exc_bus_d;

    logic [1:0]  w_off;
    logic        w_ld, w_st, w_ok, w_issue, w_misal;
    logic [31:0] w_wdata, w_load_ext;

    assign w_off   = Mem_aluout[1:0];
    assign w_ld    = is_load(Mem_op);
    assign w_st    = is_store(Mem_op);
    assign w_ok    = is_aligned(Mem_op, w_off);
    assign w_issue = (state_q == S_IDLE) && (w_ld || w_st) && w_ok && !Mem_flush;
    assign w_misal = (state_q == S_IDLE) && (w_ld || w_st) && !w_ok && !Mem_flush;

    // Store data is replicated across every lane the access could touch.
    always_comb begin
        case (Mem_op)
            OP_SH, OP_LH, OP_LHU:         w_wdata = {2{Mem_din[15:0]}};
            OP_SB, OP_LB, OP_LBU:         w_wdata = {4{Mem_din[7:0]}};
            default:                      w_wdata = Mem_din;
        endcase
    end

    load_align u_load_align (
        .i_op    (op_q),
        .i_off   (off_q),
        .i_rdata (bus.rdata),
        .o_data  (w_load_ext)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        exc_adel_d   = 1'b0;
        exc_ades_d   = 1'b0;
        exc_bus_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                exc_adel_d = w_misal && w_ld;
                exc_ades_d = w_misal && w_st;
                if (w_issue) begin
                    req_d   = 1'b1;
                    we_d    = w_st;
                    addr_d  = Mem_aluout[31:2];
                    be_d    = calc_be(Mem_op, w_off);
                    wdata_d = w_wdata;
                    op_d    = Mem_op;
                    off_d   = w_off;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack in the final allowed cycle still completes normally.
                if (bus.ack) begin
                    req_d        = 1'b0;
                    load_valid_d = is_load(op_q);
                    if (is_load(op_q)) begin
                        load_data_d = w_load_ext;
                    end
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == C_TO_LAST)) begin
                    req_d     = 1'b0;
                    exc_bus_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            op_q         <= OP_NOP;
            off_q        <= '0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            exc_adel_q   <= 1'b0;
            exc_ades_q   <= 1'b0;
            exc_bus_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            exc_adel_q   <= exc_adel_d;
            exc_ades_q   <= exc_ades_d;
            exc_bus_q    <= exc_bus_d;
        end
    end

    // Reset also masks the combinational IDLE stall so the pipeline is never frozen in reset.
    assign stall      = rst_n && (w_issue || (state_q == S_WAIT));
    assign bus.req    = req_q;
    assign bus.we     = we_q;
    assign bus.addr   = addr_q;
    assign bus.be     = be_q;
    assign bus.wdata  = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign exc_adel   = exc_adel_q;
    assign exc_ades   = exc_ades_q;
    assign exc_bus    = exc_bus_q;

endmodule
`default_nettype wire
